// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60Hz timing constants and coordinate type
package vga_timing_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/pix_tick_gen.sv
// pix_tick_gen: divides clk by TICK_DIV into a registered one-clk pixel tick
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active low
//   p_tick   out  one-clk pulse every TICK_DIV clks, first one TICK_DIV clks after release
module pix_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] div_cnt_q, div_cnt_d;
  logic p_tick_q, p_tick_d;
  always_comb begin
    div_cnt_d = div_cnt_q == LAST ? '0 : div_cnt_q + 1'b1;
    p_tick_d = div_cnt_q == LAST;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_cnt_q <= '0;
      p_tick_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      p_tick_q <= p_tick_d;
    end
  assign p_tick = p_tick_q;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel tick, h/v counters, sync, display enable and frame start
//   clk          in   system clock
//   reset_n      in   asynchronous reset, active low
//   p_tick       out  one-clk pulse per pixel period
//   pixel_x/y    out  current horizontal/vertical count
//   video_on     out  high inside the visible area
//   hsync/vsync  out  active-low sync pulses
//   frame_start  out  high on the p_tick clk that moves the counters to (0,0)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);
  localparam coord_t HD = coord_t'(H_DISPLAY);
  localparam coord_t VD = coord_t'(V_DISPLAY);
  localparam coord_t H_LAST = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t HS0 = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS1 = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS0 = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS1 = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  coord_t x_q, x_d, y_q, y_d;
  logic video_on_q, video_on_d, hsync_q, hsync_d, vsync_q, vsync_d, line_end;
  pix_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .p_tick(p_tick)
  );
  // Decode from the next-state counters so the registered sync/enable line up with pixel_x/y.
  always_comb begin
    line_end = p_tick && x_q == H_LAST;
    x_d = p_tick ? (x_q == H_LAST ? '0 : x_q + 1'b1) : x_q;
    y_d = line_end ? (y_q == V_LAST ? '0 : y_q + 1'b1) : y_q;
    video_on_d = x_d < HD && y_d < VD;
    hsync_d = !(x_d >= HS0 && x_d <= HS1);
    vsync_d = !(y_d >= VS0 && y_d <= VS1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      video_on_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      video_on_q <= video_on_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  assign pixel_x = x_q;
  assign pixel_y = y_q;
  assign video_on = video_on_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign frame_start = line_end && y_q == V_LAST;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized reset/run scoreboard against an arithmetic timing model
module tb_vga_sync_gen;
  localparam int TD = 4, HD = 16, HF = 4, HS = 6, HB = 4, VD = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB, VT = VD + VF + VS + VB, FRAME = HT * VT * TD;
  typedef struct {
    int p, x, y, v, hs, vs, fs;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic p_tick, video_on, hsync, vsync, frame_start;
  logic [9:0] pixel_x, pixel_y;
  exp_t q[$];
  int checks = 0, errors = 0, k = 0, cyc_n = 0, last_fs = -1;
  vga_sync_gen #(
    .TICK_DIV(TD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  // k = clk edges since reset release; counters have advanced once per tick seen before edge k.
  function automatic exp_t model(input int kk);
    exp_t e;
    int n;
    if (kk == 0) begin
      e = '{0, 0, 0, 0, 1, 1, 0};
      return e;
    end
    n = (kk - 1) / TD;
    e.x = n % HT;
    e.y = (n / HT) % VT;
    e.p = int'(kk >= TD && kk % TD == 0);
    e.v = int'(e.x < HD && e.y < VD);
    e.hs = int'(!(e.x >= HD + HF && e.x < HD + HF + HS));
    e.vs = int'(!(e.y >= VD + VF && e.y < VD + VF + VS));
    e.fs = int'(e.p == 1 && e.x == HT - 1 && e.y == VT - 1);
    return e;
  endfunction
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
      #2;
      q.push_back(model(k));
    end
  endtask
  // Reset is dropped 2ns after an edge, so the next negedge sample proves it acts without clk.
  task automatic hit_reset(input int hold);
    @(posedge clk);
    #2 reset_n = 1'b0;
    k = 0;
    q.push_back(model(0));
    repeat (hold) begin
      @(posedge clk);
      #2;
      q.push_back(model(0));
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    q.push_back(model(0));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("p_tick", int'(p_tick), e.p);
      cmp("pixel_x", int'(pixel_x), e.x);
      cmp("pixel_y", int'(pixel_y), e.y);
      cmp("video_on", int'(video_on), e.v);
      cmp("hsync", int'(hsync), e.hs);
      cmp("vsync", int'(vsync), e.vs);
      cmp("frame_start", int'(frame_start), e.fs);
    end
    if (!reset_n) last_fs = -1;
    else if (frame_start) begin
      if (last_fs >= 0) cmp("frame_period", cyc_n - last_fs, FRAME);
      last_fs = cyc_n;
    end
    cyc_n++;
  end
  initial begin
    hit_reset(2);
    run(2 * FRAME + 4 + $urandom_range(0, 400));
    for (int i = 0; i < 5; i++) begin
      hit_reset($urandom_range(0, 3));
      run($urandom_range(20, FRAME + 300));
    end
    @(negedge clk);
    #1;
    cmp("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
